// File: rtl/uart_tx_fifo_if.sv
// Byte-push handshake and status/line signals of the buffered UART transmitter.
// The transmitter drives the slave side; its producer uses the master side.
interface uart_tx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 16
) ();
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          stb_i;
    logic [7:0]    data_i;
    logic          rdy_o;
    logic          tx_o;
    logic          busy_o;
    logic [LW-1:0] level_o;
    logic          ovf_o;

    modport master (
        output stb_i, data_i,
        input  rdy_o, tx_o, busy_o, level_o, ovf_o
    );

    modport slave (
        input  stb_i, data_i,
        output rdy_o, tx_o, busy_o, level_o, ovf_o
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8-N-1 UART transmitter: bytes queue in a power-of-two FIFO and go out
// LSB-first with no idle gap between consecutive frames.
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    uart_tx_fifo_if.slave bus
);
    localparam int unsigned DIV = CLK_HZ / BAUDRATE;
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LW  = PW + 1;

    localparam logic [CW-1:0] BaudLoad = CW'(DIV - 1);
    localparam logic [LW-1:0] Full     = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] cnt_q;
    logic          ovf_q;

    logic rdy, push, pop, non_empty;

    // Readiness comes from registered occupancy only; a same-cycle pop never frees a slot.
    assign rdy       = (cnt_q != Full);
    assign push      = bus.stb_i && rdy;
    assign non_empty = (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + LW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - LW'(1);
            end
            if (bus.stb_i && !rdy) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (non_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BaudLoad;
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_q == '0) begin
                    baud_d  = BaudLoad;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = StData;
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            StData: begin
                if (baud_q == '0) begin
                    baud_d = BaudLoad;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            StStop: begin
                if (baud_q == '0) begin
                    // Chain straight into the next start bit so frames abut.
                    if (non_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BaudLoad;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.rdy_o   = rdy;
    assign bus.tx_o    = tx_q;
    assign bus.busy_o  = (state_q != StIdle) || non_empty;
    assign bus.level_o = cnt_q;
    assign bus.ovf_o   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at a scaled baud divider of 10 cycles per bit,
// with a line monitor that decodes frames and records start-bit cycle numbers.
module tb_uart_tx_fifo;
    localparam int unsigned CLK_HZ     = 1000;
    localparam int unsigned BAUDRATE   = 100;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned DIV        = 10;
    localparam int unsigned FRAME      = 10 * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    uart_tx_fifo #(
        .CLK_HZ    (CLK_HZ),
        .BAUDRATE  (BAUDRATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int bad_stop = 0;

    logic [7:0]  rx_q [$];
    int unsigned st_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        while (bus.busy_o !== 1'b0 && n < max) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(n >= max), 32'd0);
        tick(2);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] base, input int n);
        logic [7:0] got;
        chk({tag, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), got, 8'(base + i));
        end
    endtask

    // Line monitor: samples mid-bit on falling clock edges.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_o === 1'b0) begin
                logic [7:0]  b;
                int unsigned s;
                s = cyc;
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = bus.tx_o;
                end
                repeat (DIV) @(negedge clk);
                if (bus.tx_o !== 1'b1) bad_stop++;
                rx_q.push_back(b);
                st_q.push_back(s);
            end
        end
    end

    initial begin
        logic [9:0] line;
        int         i;
        int         n;
        int         lows;

        bus.stb_i  = 1'b0;
        bus.data_i = 8'h00;
        tick(3);
        chk("rst_tx", bus.tx_o, 1);
        chk("rst_rdy", bus.rdy_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_level", bus.level_o, 0);
        chk("rst_ovf", bus.ovf_o, 0);
        rst_n = 1'b1;
        tick(2);

        // Single byte 0x55 from idle.
        bus.stb_i  = 1'b1;
        bus.data_i = 8'h55;
        tick(1);
        bus.stb_i = 1'b0;
        chk("sb_level_acc", bus.level_o, 1);
        chk("sb_tx_acc", bus.tx_o, 1);
        tick(1);
        chk("sb_level_pop", bus.level_o, 0);
        chk("sb_busy", bus.busy_o, 1);
        line = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("sb_bit%0d_head", k), bus.tx_o, line[k]);
            tick(DIV - 1);
            chk($sformatf("sb_bit%0d_tail", k), bus.tx_o, line[k]);
            if (k == 9) chk("sb_busy_last", bus.busy_o, 1);
            tick(1);
        end
        chk("sb_busy_end", bus.busy_o, 0);
        chk("sb_tx_end", bus.tx_o, 1);
        tick(2);
        check_rx("sb_rx", 8'h55, 1);
        rx_q.delete();
        st_q.delete();

        // Back-to-back burst "?" then CR.
        bus.stb_i  = 1'b1;
        bus.data_i = 8'h3F;
        tick(1);
        bus.data_i = 8'h0D;
        tick(1);
        bus.stb_i = 1'b0;
        wait_idle(3 * FRAME, "bu_timeout");
        chk("bu_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("bu_byte0", rx_q[0], 8'h3F);
            chk("bu_byte1", rx_q[1], 8'h0D);
            chk("bu_spacing", st_q[1] - st_q[0], FRAME);
        end
        rx_q.delete();
        st_q.delete();

        // Overflow: 20 consecutive strobes into a 16-deep FIFO.
        for (int k = 0; k < 20; k++) begin
            bus.stb_i  = 1'b1;
            bus.data_i = 8'(k);
            tick(1);
            if (k == 16) begin
                chk("ov_rdy_full", bus.rdy_o, 0);
                chk("ov_level_full", bus.level_o, 16);
                chk("ov_ovf_before", bus.ovf_o, 0);
            end
            if (k == 17) chk("ov_ovf_set", bus.ovf_o, 1);
        end
        bus.stb_i = 1'b0;
        wait_idle(20 * FRAME, "ov_timeout");
        check_rx("ov_rx", 8'h00, 17);
        if (st_q.size() == 17) chk("ov_spacing", st_q[16] - st_q[0], 16 * FRAME);
        chk("ov_ovf_sticky", bus.ovf_o, 1);

        // Reset 30 cycles into a frame of 0xA3 with three bytes queued.
        bus.stb_i  = 1'b1;
        bus.data_i = 8'hA3;
        tick(1);
        bus.data_i = 8'h01;
        tick(1);
        bus.data_i = 8'h02;
        tick(1);
        bus.data_i = 8'h03;
        tick(1);
        bus.stb_i = 1'b0;
        chk("mr_level_queued", bus.level_o, 3);
        tick(28);
        chk("mr_busy_pre", bus.busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_tx", bus.tx_o, 1);
        chk("mr_level", bus.level_o, 0);
        chk("mr_busy", bus.busy_o, 0);
        chk("mr_ovf", bus.ovf_o, 0);
        tick(3);
        rst_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 2000; k++) begin
            tick(1);
            if (bus.tx_o !== 1'b1) lows++;
        end
        chk("mr_quiet", lows, 0);
        chk("mr_busy_after", bus.busy_o, 0);
        rx_q.delete();
        st_q.delete();

        // Pointer wrap: 40 bytes pushed whenever ready.
        i = 0;
        n = 0;
        while (i < 40 && n < 10000) begin
            if (bus.rdy_o) begin
                bus.stb_i  = 1'b1;
                bus.data_i = 8'(8'h30 + i);
                i++;
            end else begin
                bus.stb_i = 1'b0;
            end
            tick(1);
            n++;
        end
        bus.stb_i = 1'b0;
        chk("wr_pushed", i, 40);
        wait_idle(45 * FRAME, "wr_timeout");
        check_rx("wr_rx", 8'h30, 40);
        chk("wr_ovf", bus.ovf_o, 0);
        rx_q.delete();
        st_q.delete();

        // Strobe at a STOP expiry while full: pop happens, push is refused.
        for (int k = 0; k < 17; k++) begin
            bus.stb_i  = 1'b1;
            bus.data_i = 8'(8'h60 + k);
            tick(1);
        end
        bus.stb_i = 1'b0;
        chk("fp_level_full", bus.level_o, 16);
        chk("fp_rdy_full", bus.rdy_o, 0);
        chk("fp_ovf_before", bus.ovf_o, 0);
        tick(FRAME - 16);
        chk("fp_tx_stop", bus.tx_o, 1);
        bus.stb_i  = 1'b1;
        bus.data_i = 8'hEE;
        tick(1);
        bus.stb_i = 1'b0;
        chk("fp_level_after", bus.level_o, 15);
        chk("fp_ovf_after", bus.ovf_o, 1);
        chk("fp_tx_start", bus.tx_o, 0);
        chk("fp_rdy_after", bus.rdy_o, 1);
        wait_idle(20 * FRAME, "fp_timeout");
        check_rx("fp_rx", 8'h60, 17);

        chk("stop_bits", bad_stop, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8-N-1 UART transmitter. It is the outbound counterpart of `uart_rx`. It accepts bytes over a strobe/ready handshake into a power-of-two FIFO and serializes them LSB-first onto the line, with no idle gap between frames. The debug controller uses it to drive `uart_tx_o` in `top`, so multi-character responses can be queued in one burst instead of byte-by-byte pacing.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, input clock frequency in Hz
- `BAUDRATE`, 115200, line rate in baud
- `FIFO_DEPTH`, 16, FIFO entries; power of two, at least 2

Ports:
- `clk_i`  in  1  single clock for all logic
- `rst_ni`  in  1  asynchronous, active-low reset
- `stb_i`  in  1  write strobe; each high cycle with `rdy_o`=1 pushes one byte
- `data_i`  in  8  byte to transmit, sampled when `stb_i`=1
- `rdy_o`  out  1  FIFO not full
- `tx_o`  out  1  serial line; idle level 1
- `busy_o`  out  1  frame in progress or FIFO non-empty
- `level_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH
- `ovf_o`  out  1  sticky flag: a push was attempted while full

## Operation
- `DIV` = CLK_HZ/BAUDRATE, integer truncated. The defaults give 868.
- Every bit, including start and stop, is held exactly `DIV` cycles, so one frame is 10·`DIV` cycles.
- FIFO:
  - Circular buffer with read and write pointers and an occupancy counter.
  - Push when `stb_i && rdy_o`.
  - `stb_i` while `rdy_o`=0 drops the byte, sets `ovf_o`, and leaves the FIFO unchanged.
  - `rdy_o` is computed from the registered occupancy only. A pop in the same cycle does not free a slot for a push.
  - Simultaneous push and pop: occupancy unchanged, both pointers advance.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx_o`=1. If the FIFO is non-empty, pop the head into the shift register, load the baud counter, go to START.
  - START: `tx_o`=0 for `DIV` cycles, then DATA with bit index 0.
  - DATA: `tx_o`=shift[0] for `DIV` cycles per bit, shifting right. After bit 7 go to STOP.
  - STOP: `tx_o`=1 for `DIV` cycles. At expiry, if the FIFO is non-empty, pop and go straight to START in the same cycle with no idle cycle. Otherwise go to IDLE.
- Counters:
  - The baud counter counts `DIV`-1 down to 0.
  - The bit index is 3 bits.
- `tx_o` is a registered output (glitch-free).
- `busy_o` = (state ≠ IDLE) or (occupancy ≠ 0).
- `ovf_o` clears only on reset.

## Timing
- Reset values:
  - `tx_o`=1, `rdy_o`=1, `busy_o`=0, `level_o`=0, `ovf_o`=0.
  - FSM in IDLE, FIFO empty.
  - Reset takes effect asynchronously. A frame in flight is abandoned and `tx_o` returns to 1 immediately.
- Latency, idle and empty case:
  - Byte accepted at edge N; `level_o`=1 after N.
  - Pop at edge N+1; `tx_o` falls and `level_o` returns to 0 after edge N+1.
- Back-to-back frames:
  - Each next start bit begins exactly 10·`DIV` cycles after the previous one.
  - `level_o` decrements at each frame start.
- `busy_o` falls on the edge where STOP expires with an empty FIFO. `tx_o` stays 1 at that point.
- `stb_i` held high for k cycles means k pushes; the block does no edge detection.
- Reset release: no transmission until a new push.

## Test plan
- **Single byte.** Push 0x55 while idle.
  - `tx_o` low 1 cycle after the accept edge.
  - Line sequence: 0, 1,0,1,0,1,0,1,0, 1, each level held 868 cycles.
  - `busy_o` low exactly 8680 cycles after `tx_o` first falls.
- **Loopback burst.** Push "?" (0x3F) then 0x0D on consecutive cycles, with a `uart_rx` instance on `tx_o`.
  - Monitor strobes 0x3F, then 0x0D.
  - Second start bit begins exactly 8680 cycles after the first.
- **Overflow.** Push 20 bytes 0x00..0x13 on consecutive cycles with the default depth.
  - 17 accepted (the first is popped at edge 2); `rdy_o`=0 after the 17th.
  - `ovf_o`=1 from the 18th strobe on.
  - Bytes 0x00..0x10 emitted in order; 0x11..0x13 never appear.
- **Reset mid-frame.** Assert `rst_ni`=0 3000 cycles into a frame carrying 0xA3, with 3 bytes queued.
  - `tx_o`=1 with no clock edge; `level_o`=0, `busy_o`=0.
  - After release, `tx_o` stays 1 for 20000 cycles.
- **Pointer wrap.** Send 40 bytes 0x30..0x57 by pushing whenever `rdy_o`=1.
  - Loopback monitor receives all 40 in order.
  - `ovf_o` stays 0.
- **Push/pop same cycle at full.**
  - Fill the FIFO.
  - At a STOP expiry edge, present `stb_i` with 0xEE.
  - Required: 0xEE dropped, `ovf_o`=1, `level_o`=`FIFO_DEPTH`-1 after that edge.
